kudu_branch_tracer: RTL
=======================

KUDU_BRANCH_TRACER -- requirements
Module: kudu_branch_tracer

Interface
REQ-001 Parameter NLANES, default 2: issue lanes monitored, 1..4.
REQ-002 Parameter DEPTH, default 16: trace FIFO entries, power of 2, >= NLANES.
REQ-003 Parameter CNT_W, default 32: statistics counter width.
REQ-004 Parameter SEQ_W, default 16: record sequence-number width.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 start_stop_i  in  1  single-cycle pulse; toggles logging enable.
REQ-008 clear_i  in  1  synchronous clear of counters, FIFO and sequence number.
REQ-009 miss_only_i  in  1  filter mode: 1 = record only mispredicted branches.
REQ-010 br_valid_i  in  NLANES  lane i issued a branch this cycle.
REQ-011 br_taken_i  in  NLANES  branch outcome per lane.
REQ-012 br_miss_i  in  NLANES  mispredict flag per lane.
REQ-013 br_pc_i  in  NLANES x 32  branch PC per lane.
REQ-014 br_target_i  in  NLANES x 32  branch target per lane.
REQ-015 log_en_o  out  1  current logging enable.
REQ-016 rec_valid_o  out  1  trace record available.
REQ-017 rec_ready_i  in  1  consumer accepts record.
REQ-018 rec_o  out  SEQ_W+67  record {seq, pc, target, taken, miss, fwd}.
REQ-019 cnt_branch_o, cnt_taken_o, cnt_miss_o, cnt_fwd_o, cnt_drop_o  out  CNT_W each  statistics.
REQ-020 fifo_level_o  out  clog2(DEPTH)+1  occupancy.

Function
REQ-021 log_en toggles on each start_stop_i pulse; all capture and counting is gated by log_en as registered before the edge.
REQ-022 An event is lane i with br_valid_i[i] and log_en; it is eligible for recording when miss_only_i=0 or br_miss_i[i]=1.
REQ-023 fwd = 1 iff br_pc_i < br_target_i (unsigned); equal addresses give fwd = 0.
REQ-024 Counters count all events regardless of filter: branch += events, taken += events with taken, miss += events with miss, fwd += events with fwd.
REQ-025 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-026 Eligible events are written in ascending lane order, all in the same cycle, with consecutive seq values.
REQ-027 Free space is DEPTH - level, with a same-cycle pop adding no space. If eligible events exceed free space, the lowest lanes are written up to the free space and the rest are dropped.
REQ-028 cnt_drop increments by the number of dropped records (saturating), and seq still advances for dropped records so the consumer detects gaps.
REQ-029 seq is SEQ_W bits and wraps modulo 2^SEQ_W.
REQ-030 Write-to-output latency is 1 cycle: an event in cycle N into an empty FIFO gives rec_valid_o=1 in cycle N+1.
REQ-031 rec_o is the FIFO head. A pop occurs when rec_valid_o and rec_ready_i are both 1.
REQ-032 rec_o and rec_valid_o stay stable while rec_valid_o=1 and rec_ready_i=0.
REQ-033 A simultaneous push and pop updates level by (pushes - 1) in one cycle. Pointers wrap modulo DEPTH.
REQ-034 When clear_i=1, that cycle's events are discarded. Counters, seq, level and pointers become 0 on the next edge. log_en is unaffected except for toggling when start_stop_i is high in the same cycle.
REQ-035 Stopping logging does not flush the FIFO; the consumer may drain remaining records while log_en=0.

Reset
REQ-036 rst_i asserted asynchronously forces log_en_o=0, rec_valid_o=0, fifo_level_o=0, all counters 0 and seq 0, including mid-operation with a partially full FIFO.
REQ-037 rec_o contents are don't-care while rec_valid_o=0.
REQ-038 The first start_stop_i pulse after rst_i deasserts sets log_en_o=1.

Verification
REQ-039 Pulse start_stop; lane0 branch pc=0x100, target=0x80, taken, no miss -> next cycle rec {seq 0, fwd 0, taken 1, miss 0}; cnt_branch=1, cnt_fwd=0.
REQ-040 Both lanes branch in one cycle with pc < target and miss on lane1 -> two records, seq 0 then 1, lane0 first; cnt_miss=1, cnt_fwd=2.
REQ-041 Hold rec_ready=0 and drive 2 branches/cycle for 9 cycles with DEPTH=16 -> level=16, cnt_drop=2, last recorded seq 15, next accepted record carries seq 18.
REQ-042 Set miss_only=1 and send 4 branches, 1 mispredicted -> 1 record; cnt_branch=4.
REQ-043 Assert rst_i mid-burst with level=7 -> rec_valid=0, level=0, all counters 0 immediately, without waiting for a clock edge.
REQ-044 Assert clear_i together with start_stop while logging -> counters and level 0, log_en=0; force cnt_taken to max-1, add 3 taken branches -> cnt_taken saturates at max.

Source files
------------

// File: rtl/kudu_branch_tracer.sv
// kudu_branch_tracer: captures branches from up to four issue lanes into a trace FIFO
// with gap-revealing sequence numbers, plus saturating per-kind statistics counters.
module kudu_branch_tracer #(
  parameter int  NLANES = 2,
  parameter int  DEPTH  = 16,
  parameter int  CNT_W  = 32,
  parameter int  SEQ_W  = 16,
  localparam int LW     = $clog2(DEPTH) + 1,
  localparam int REC_W  = SEQ_W + 67
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_stop_i,
  input  logic                    clear_i,
  input  logic                    miss_only_i,
  input  logic [NLANES-1:0]       br_valid_i,
  input  logic [NLANES-1:0]       br_taken_i,
  input  logic [NLANES-1:0]       br_miss_i,
  input  logic [NLANES-1:0][31:0] br_pc_i,
  input  logic [NLANES-1:0][31:0] br_target_i,
  output logic                    log_en_o,
  output logic                    rec_valid_o,
  input  logic                    rec_ready_i,
  output logic [REC_W-1:0]        rec_o,
  output logic [CNT_W-1:0]        cnt_branch_o,
  output logic [CNT_W-1:0]        cnt_taken_o,
  output logic [CNT_W-1:0]        cnt_miss_o,
  output logic [CNT_W-1:0]        cnt_fwd_o,
  output logic [CNT_W-1:0]        cnt_drop_o,
  output logic [LW-1:0]           fifo_level_o
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_N = 2 ** AW;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W + 1)'(b);
    if (sum[CNT_W]) begin
      sat_add = '1;
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  logic               log_en_q, log_en_d;
  logic               rec_valid_q, rec_valid_d;
  logic [LW-1:0]      level_q, level_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [CNT_W-1:0]   cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0]   cnt_tk_q, cnt_tk_d;
  logic [CNT_W-1:0]   cnt_ms_q, cnt_ms_d;
  logic [CNT_W-1:0]   cnt_fw_q, cnt_fw_d;
  logic [CNT_W-1:0]   cnt_dr_q, cnt_dr_d;
  logic [REC_W-1:0]   mem_q [MEM_N];
  logic [REC_W-1:0]   mem_d [MEM_N];

  logic [LW-1:0]      free;
  logic               pop;
  logic               ev, elig, fwd, slot_ok;
  logic [2:0]         n_ev, n_tk, n_ms, n_fw, n_elig, n_push, n_drop;

  // Lane scan: filter, slot allocation in lane order, drop accounting and next state.
  always_comb begin
    mem_d   = mem_q;
    n_ev    = 3'd0;
    n_tk    = 3'd0;
    n_ms    = 3'd0;
    n_fw    = 3'd0;
    n_elig  = 3'd0;
    n_push  = 3'd0;
    n_drop  = 3'd0;
    ev      = 1'b0;
    elig    = 1'b0;
    fwd     = 1'b0;
    slot_ok = 1'b0;
    // A pop in this cycle frees nothing for this cycle's writes.
    free    = LW'(DEPTH) - level_q;
    pop     = rec_valid_q & rec_ready_i;
    for (int i = 0; i < NLANES; i++) begin
      ev      = br_valid_i[i] & log_en_q & ~clear_i;
      elig    = ev & (~miss_only_i | br_miss_i[i]);
      fwd     = br_pc_i[i] < br_target_i[i];
      slot_ok = elig & ((LW + 3)'(n_push) < (LW + 3)'(free));
      mem_d[wr_ptr_q + AW'(n_push)] = slot_ok ?
          {seq_q + SEQ_W'(n_elig), br_pc_i[i], br_target_i[i], br_taken_i[i], br_miss_i[i], fwd} :
          mem_d[wr_ptr_q + AW'(n_push)];
      n_ev   = n_ev   + {2'b00, ev};
      n_tk   = n_tk   + {2'b00, ev & br_taken_i[i]};
      n_ms   = n_ms   + {2'b00, ev & br_miss_i[i]};
      n_fw   = n_fw   + {2'b00, ev & fwd};
      n_push = n_push + {2'b00, slot_ok};
      n_drop = n_drop + {2'b00, elig & ~slot_ok};
      n_elig = n_elig + {2'b00, elig};
    end

    log_en_d = log_en_q ^ start_stop_i;
    if (clear_i) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      seq_d    = '0;
      cnt_br_d = '0;
      cnt_tk_d = '0;
      cnt_ms_d = '0;
      cnt_fw_d = '0;
      cnt_dr_d = '0;
    end else begin
      level_d  = level_q + LW'(n_push) - LW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(n_push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      seq_d    = seq_q + SEQ_W'(n_elig);
      cnt_br_d = sat_add(cnt_br_q, n_ev);
      cnt_tk_d = sat_add(cnt_tk_q, n_tk);
      cnt_ms_d = sat_add(cnt_ms_q, n_ms);
      cnt_fw_d = sat_add(cnt_fw_q, n_fw);
      cnt_dr_d = sat_add(cnt_dr_q, n_drop);
    end
    rec_valid_d = (level_d != '0);
  end

  // Control, pointer and statistics state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      log_en_q    <= 1'b0;
      rec_valid_q <= 1'b0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      seq_q       <= '0;
      cnt_br_q    <= '0;
      cnt_tk_q    <= '0;
      cnt_ms_q    <= '0;
      cnt_fw_q    <= '0;
      cnt_dr_q    <= '0;
    end else begin
      log_en_q    <= log_en_d;
      rec_valid_q <= rec_valid_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      seq_q       <= seq_d;
      cnt_br_q    <= cnt_br_d;
      cnt_tk_q    <= cnt_tk_d;
      cnt_ms_q    <= cnt_ms_d;
      cnt_fw_q    <= cnt_fw_d;
      cnt_dr_q    <= cnt_dr_d;
    end
  end

  // Trace storage; contents only matter while the level says they are live.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign log_en_o     = log_en_q;
  assign rec_valid_o  = rec_valid_q;
  assign rec_o        = mem_q[rd_ptr_q];
  assign fifo_level_o = level_q;
  assign cnt_branch_o = cnt_br_q;
  assign cnt_taken_o  = cnt_tk_q;
  assign cnt_miss_o   = cnt_ms_q;
  assign cnt_fwd_o    = cnt_fw_q;
  assign cnt_drop_o   = cnt_dr_q;

endmodule
